onehot_decoder_scan: RTL and testbench

Parametrised, registered binary-to-one-hot decoder, the next generation of the team's 2-to-4 decoders. It has two modes:
- Direct mode: decodes an input code accepted through a valid/ready handshake.
- Scan mode: an internal counter steps through every output slot with a programmable dwell time, for LED digit, keypad column and bank-select strobing.
It sits between control logic and any one-hot select bus.

---
 rtl/onehot_decoder_pkg.sv | 25 ++
 rtl/scan_code_ctr.sv | 103 ++++++++++
 rtl/onehot_decoder_scan.sv | 110 +++++++++++
 tb/tb_onehot_decoder_scan.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_pkg.sv
// Shared state encoding and decode helper for onehot_decoder_scan and its scan counter.
// The helper works at the widest supported code width; callers keep the low 2**IN_W bits.
package onehot_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam int DWELL_MAX  = 65535;
    localparam int CODE_W_MAX = 8;
    localparam int OUT_W_MAX  = 2 ** CODE_W_MAX;

    function automatic logic [OUT_W_MAX-1:0] onehot_decode(
        input logic [CODE_W_MAX-1:0] code,
        input logic                  active_low
    );
        logic [OUT_W_MAX-1:0] vec;
        vec       = '0;
        vec[code] = 1'b1;
        return active_low ? ~vec : vec;
    endfunction

endpackage

// File: rtl/scan_code_ctr.sv
// Dwell counter and code counter for scan mode, with mask-aware slot skipping.
// Also holds the code loaded by direct-mode accepts so cur_code has a single owner.
module scan_code_ctr
    import onehot_decoder_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scan_start,
    input  logic                 scan_run,
    input  logic                 load,
    input  logic [IN_W-1:0]      load_code,
    input  logic [2**IN_W-1:0]   scan_mask,
    output logic [IN_W-1:0]      code_q,
    output logic [IN_W-1:0]      code_d,
    output logic                 live_d,
    output logic                 wrap_q
);

    localparam int OUT_W = 2 ** IN_W;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [DW_W-1:0] dwell_q, dwell_d;
    logic            live_q;
    logic            wrap_d;

    logic [IN_W-1:0]  next_cand [OUT_W];
    logic [OUT_W-1:0] next_hit;
    logic             next_found, first_found;
    logic [IN_W-1:0]  next_code, first_code;

    // Candidate i is code_q+i+1; the last candidate wraps round to code_q itself.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_cand
            assign next_cand[gi] = code_q + IN_W'(gi + 1);
            assign next_hit[gi]  = ~scan_mask[next_cand[gi]];
        end
    endgenerate

    always_comb begin
        next_found  = 1'b0;
        next_code   = code_q;
        first_found = 1'b0;
        first_code  = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            if (next_hit[i]) begin
                next_found = 1'b1;
                next_code  = next_cand[i];
            end
            if (!scan_mask[i]) begin
                first_found = 1'b1;
                first_code  = IN_W'(i);
            end
        end
    end

    always_comb begin
        dwell_d = dwell_q;
        code_d  = code_q;
        live_d  = live_q;
        wrap_d  = 1'b0;
        if (load) begin
            code_d = load_code;
        end
        if (scan_start) begin
            dwell_d = '0;
            code_d  = first_code;
            live_d  = first_found;
        end else if (scan_run) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                live_d  = next_found;
                if (next_found) begin
                    code_d = next_code;
                    wrap_d = (next_code < code_q);
                end
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end else begin
            dwell_d = '0;
            live_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q <= '0;
            code_q  <= '0;
            live_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            code_q  <= code_d;
            live_q  <= live_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule

// File: rtl/onehot_decoder_scan.sv
// Registered binary-to-one-hot decoder with a handshaked direct mode and a strobing scan mode.
// Define ONEHOT_DECODER_SCAN_MASK_EN to add the scan_mask input that skips slots while scanning.
module onehot_decoder_scan
    import onehot_decoder_pkg::*;
#(
    parameter int IN_W       = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [IN_W-1:0]      din,
    input  logic                 in_valid,
`ifdef ONEHOT_DECODER_SCAN_MASK_EN
    input  logic [2**IN_W-1:0]   scan_mask,
`endif
    output logic                 in_ready,
    output logic [2**IN_W-1:0]   dout,
    output logic                 out_valid,
    output logic [IN_W-1:0]      cur_code,
    output logic                 scan_wrap
);

    localparam int OUT_W = 2 ** IN_W;
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

    state_e           state_q, state_d, target;
    logic             accept, scan_start, scan_run;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] decoded;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             out_valid_q, out_valid_d;
    logic [IN_W-1:0]  code_q, code_d;
    logic             live_d, wrap_q;

`ifdef ONEHOT_DECODER_SCAN_MASK_EN
    assign mask = scan_mask;
`else
    assign mask = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any change of the requested state from a non-idle state spends one cycle in IDLE.
    always_comb begin
        target = IDLE;
        if (en) begin
            target = mode ? SCAN : DIRECT;
        end
        state_d = ((state_q == IDLE) || (state_q == target)) ? target : IDLE;
    end

    always_comb begin
        in_ready   = en && !mode && rst_n;
        accept     = in_valid && in_ready && (state_d == DIRECT);
        scan_start = (state_d == SCAN) && (state_q != SCAN);
        scan_run   = (state_d == SCAN) && (state_q == SCAN);
    end

    scan_code_ctr #(
        .IN_W  (IN_W),
        .DWELL (DWELL)
    ) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_start (scan_start),
        .scan_run   (scan_run),
        .load       (accept),
        .load_code  (din),
        .scan_mask  (mask),
        .code_q     (code_q),
        .code_d     (code_d),
        .live_d     (live_d),
        .wrap_q     (wrap_q)
    );

    always_comb begin
        decoded = OUT_W'(onehot_decode(CODE_W_MAX'(code_d), ACTIVE_LOW));
        case (state_d)
            DIRECT:  out_valid_d = accept || out_valid_q;
            SCAN:    out_valid_d = live_d;
            default: out_valid_d = 1'b0;
        endcase
        dout_d = out_valid_d ? decoded : INACTIVE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q      <= INACTIVE;
            out_valid_q <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign cur_code  = code_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_scan.sv
// Bench for onehot_decoder_scan: two instances (DWELL=3 active-high, DWELL=1 active-low)
// share one stimulus stream and are checked every cycle against a slot-level model.
module tb_onehot_decoder_scan;

    logic       clk = 1'b0;
    logic       rst_n, en, mode, in_valid;
    logic [1:0] din;
    logic [3:0] scan_mask;
    logic       in_ready0, in_ready1, ov0, ov1, wrap0, wrap1;
    logic [3:0] dout0, dout1;
    logic [1:0] cc0, cc1;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Model: phase 0=idle 1=direct 2=scan, current slot, cycles spent in slot.
    int m_st[2]    = '{0, 0};
    int m_code[2]  = '{0, 0};
    int m_dwell[2] = '{0, 0};
    bit m_valid[2] = '{0, 0};
    bit m_wrap[2]  = '{0, 0};

    always #5 clk = ~clk;

    onehot_decoder_scan #(.IN_W(2), .DWELL(3), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din), .in_valid(in_valid),
`ifdef ONEHOT_DECODER_SCAN_MASK_EN
        .scan_mask(scan_mask),
`endif
        .in_ready(in_ready0), .dout(dout0), .out_valid(ov0), .cur_code(cc0), .scan_wrap(wrap0)
    );

    onehot_decoder_scan #(.IN_W(2), .DWELL(1), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din), .in_valid(in_valid),
`ifdef ONEHOT_DECODER_SCAN_MASK_EN
        .scan_mask(scan_mask),
`endif
        .in_ready(in_ready1), .dout(dout1), .out_valid(ov1), .cur_code(cc1), .scan_wrap(wrap1)
    );

    function automatic int dwell_of(int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int exp_dout(int k);
        int v;
        v = m_valid[k] ? (1 << m_code[k]) : 0;
        if (k == 1) v = (~v) & 15;
        return v;
    endfunction

    function automatic bit masked(int c);
`ifdef ONEHOT_DECODER_SCAN_MASK_EN
        return scan_mask[c];
`else
        return (c < 0);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin : model
        int tgt, nst, nc;
        bit found;
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            if (!rst_n) begin
                m_st[k] = 0; m_code[k] = 0; m_dwell[k] = 0; m_valid[k] = 1'b0;
            end else begin
                tgt = !en ? 0 : (mode ? 2 : 1);
                nst = ((m_st[k] == 0) || (m_st[k] == tgt)) ? tgt : 0;
                if (nst == 0) begin
                    m_valid[k] = 1'b0;
                    m_dwell[k] = 0;
                end else if (nst == 1) begin
                    m_dwell[k] = 0;
                    if (in_valid) begin
                        m_code[k]  = din;
                        m_valid[k] = 1'b1;
                    end
                end else if (m_st[k] != 2) begin
                    m_dwell[k] = 0;
                    m_code[k]  = 0;
                    m_valid[k] = 1'b0;
                    for (int c = 3; c >= 0; c--) begin
                        if (!masked(c)) begin
                            m_code[k]  = c;
                            m_valid[k] = 1'b1;
                        end
                    end
                end else if (m_dwell[k] == dwell_of(k) - 1) begin
                    m_dwell[k] = 0;
                    found = 1'b0;
                    nc = m_code[k];
                    for (int j = 4; j >= 1; j--) begin
                        if (!masked((m_code[k] + j) % 4)) begin
                            found = 1'b1;
                            nc = (m_code[k] + j) % 4;
                        end
                    end
                    m_valid[k] = found;
                    if (found) begin
                        m_wrap[k] = (nc < m_code[k]);
                        m_code[k] = nc;
                    end
                end else begin
                    m_dwell[k] = m_dwell[k] + 1;
                end
                m_st[k] = nst;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("dout0",     dout0,     exp_dout(0));
            check("valid0",    ov0,       m_valid[0]);
            check("code0",     cc0,       m_code[0]);
            check("wrap0",     wrap0,     m_wrap[0]);
            check("in_ready0", in_ready0, en && !mode && rst_n);
            check("dout1",     dout1,     exp_dout(1));
            check("valid1",    ov1,       m_valid[1]);
            check("code1",     cc1,       m_code[1]);
            check("wrap1",     wrap1,     m_wrap[1]);
            check("in_ready1", in_ready1, en && !mode && rst_n);
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; din = 2'd0; in_valid = 1'b0; scan_mask = 4'b0000;
        cmp_en = 1'b1;

        nxt();
        check("rst_dout0", dout0, 4'b0000);
        check("rst_dout1", dout1, 4'b1111);
        check("rst_valid0", ov0, 0);
        check("rst_code0", cc0, 0);
        check("rst_wrap0", wrap0, 0);

        rst_n = 1'b1; mode = 1'b0; din = 2'd2; in_valid = 1'b1;
        nxt();
        check("dir_dout_2", dout0, 4'b0100);
        check("dir_valid", ov0, 1);
        check("dir_ready", in_ready0, 1);
        din = 2'd1;
        nxt();
        check("dir_dout_1", dout0, 4'b0010);
        check("dir_ready", in_ready0, 1);
        din = 2'd3;
        nxt();
        check("dir_dout_3", dout0, 4'b1000);
        check("dir_code_3", cc0, 3);
        check("dir_ready", in_ready0, 1);
        in_valid = 1'b0;
        nxt();
        check("dir_hold", dout0, 4'b1000);
        mode = 1'b1;
        nxt();
        check("idle_dout", dout0, 4'b0000);
        check("idle_valid", ov0, 0);

        for (int i = 0; i <= 12; i++) begin
            nxt();
            check("scan_code0", cc0, (i / 3) % 4);
            check("scan_dout0", dout0, 1 << ((i / 3) % 4));
            check("scan_wrap0", wrap0, (i == 12));
            check("scan_dout1", dout1, (~(1 << (i % 4))) & 15);
            check("scan_wrap1", wrap1, (i > 0) && (i % 4 == 0));
        end
        repeat (6) nxt();
        check("scan_code0_at2", cc0, 2);
        en = 1'b0;
        nxt();
        check("en_off_dout0", dout0, 4'b0000);
        check("en_off_valid0", ov0, 0);
        check("en_off_code0", cc0, 2);
        check("en_off_dout1", dout1, 4'b1111);
        en = 1'b1;
        nxt();
        check("rescan_code0", cc0, 0);
        check("rescan_dout0", dout0, 4'b0001);
        mode = 1'b0;
        nxt();
        check("sw_idle_valid", ov0, 0);
        check("sw_idle_dout", dout0, 4'b0000);
        check("sw_ready", in_ready0, 1);
        nxt();
        check("sw_direct_novalid", ov0, 0);
        mode = 1'b1;
        repeat (5) nxt();
        rst_n = 1'b0;
        nxt();
        check("midscan_rst_code", cc0, 0);
        check("midscan_rst_valid", ov0, 0);
        rst_n = 1'b1;

`ifdef ONEHOT_DECODER_SCAN_MASK_EN
        scan_mask = 4'b0101;
        nxt();
        check("mask_first", cc0, 1);
        check("mask_first_dout", dout0, 4'b0010);
        repeat (3) nxt();
        check("mask_skip", cc0, 3);
        repeat (3) nxt();
        check("mask_wrap_code", cc0, 1);
        check("mask_wrap", wrap0, 1);
        scan_mask = 4'b1111;
        repeat (3) nxt();
        check("mask_all_valid", ov0, 0);
        check("mask_all_dout", dout0, 4'b0000);
        check("mask_all_code", cc0, 1);
        scan_mask = 4'b0111;
        repeat (3) nxt();
        check("mask_resume", cc0, 3);
        check("mask_resume_dout", dout0, 4'b1000);
        scan_mask = 4'b0000;
`endif

        for (int n = 0; n < 4000; n++) begin
            nxt();
            rst_n    = ($urandom_range(0, 99) != 0);
            en       = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 23) == 0) mode = ~mode;
            din      = 2'($urandom);
            in_valid = 1'($urandom);
`ifdef ONEHOT_DECODER_SCAN_MASK_EN
            if ($urandom_range(0, 29) == 0)
                scan_mask = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
`endif
        end
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
